// File: rtl/ro_pair_counter_if.sv
// ro_pair_counter_if: start/status/count bundle between the requester and the measurement stage.
interface ro_pair_counter_if #(
    parameter int unsigned CNT_W = 4
);
    logic             start;
    logic             busy;
    logic             valid;
    logic [CNT_W-1:0] count0;
    logic [CNT_W-1:0] count1;

    // Requester / comparator side
    modport master (
        output start,
        input  busy,
        input  valid,
        input  count0,
        input  count1
    );

    // Measurement stage side
    modport slave (
        input  start,
        output busy,
        output valid,
        output count0,
        output count1
    );
endinterface

// File: rtl/ro_pair_counter.sv
// ro_pair_counter: counts rising edges of two asynchronous ring-oscillator
// outputs over a fixed WINDOW-cycle window and presents both final counts with
// a one-cycle valid strobe. Build macro RO_CNT_SAT_EN selects saturating edge
// counters; without it the counters wrap modulo 2^CNT_W.
module ro_pair_counter #(
    parameter int unsigned CNT_W  = 4,
    parameter int unsigned WINDOW = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ro0,
    input  logic             ro1,
    ro_pair_counter_if.slave bus
);
    localparam int unsigned      TMR_W    = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [2:0]       r_sync0;
    logic [2:0]       r_sync1;
    logic [CNT_W-1:0] r_c0;
    logic [CNT_W-1:0] r_c1;
    logic [TMR_W-1:0] r_timer;
    logic             r_busy;
    logic             r_valid;
    logic [CNT_W-1:0] r_count0;
    logic [CNT_W-1:0] r_count1;

    logic             w_edge0;
    logic             w_edge1;
    logic [CNT_W-1:0] w_c0_inc;
    logic [CNT_W-1:0] w_c1_inc;
    logic             w_timer_zero;
    logic             w_clear;
    logic             w_run;
    logic             w_capture;
    logic             w_busy_nxt;
    logic             w_valid_nxt;

    // Two synchronizer stages plus one history stage per oscillator, always running
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync0 <= '0;
            r_sync1 <= '0;
        end else begin
            r_sync0 <= {r_sync0[1:0], ro0};
            r_sync1 <= {r_sync1[1:0], ro1};
        end
    end

    assign w_edge0      = r_sync0[1] & ~r_sync0[2];
    assign w_edge1      = r_sync1[1] & ~r_sync1[2];
    assign w_timer_zero = (r_timer == '0);

`ifdef RO_CNT_SAT_EN
    // Saturating increment: once at all-ones, further edges are dropped
    assign w_c0_inc = (w_edge0 && (r_c0 != CNT_MAX)) ? (r_c0 + CNT_W'(1)) : r_c0;
    assign w_c1_inc = (w_edge1 && (r_c1 != CNT_MAX)) ? (r_c1 + CNT_W'(1)) : r_c1;
`else
    // Wrapping increment modulo 2^CNT_W; CNT_MAX only matters for the saturating build
    assign w_c0_inc = r_c0 + CNT_W'(w_edge0);
    assign w_c1_inc = r_c1 + CNT_W'(w_edge1);
    logic w_unused_max;
    assign w_unused_max = &CNT_MAX;
`endif

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: DONE always returns to IDLE, start only seen in IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.start)   w_state_nxt = S_COUNT;
            S_COUNT: if (w_timer_zero) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output/control decode from current and next state
    always_comb begin
        w_clear     = 1'b0;
        w_run       = 1'b0;
        w_capture   = 1'b0;
        w_busy_nxt  = (w_state_nxt != S_IDLE);
        w_valid_nxt = (w_state_nxt == S_DONE);
        if (r_state == S_IDLE) begin
            w_clear = bus.start;
        end
        if (r_state == S_COUNT) begin
            w_run     = 1'b1;
            w_capture = w_timer_zero;
        end
    end

    // Window timer and internal edge counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_c0    <= '0;
            r_c1    <= '0;
            r_timer <= '0;
        end else if (w_clear) begin
            r_c0    <= '0;
            r_c1    <= '0;
            r_timer <= TMR_LOAD;
        end else if (w_run) begin
            r_c0 <= w_c0_inc;
            r_c1 <= w_c1_inc;
            if (!w_timer_zero) begin
                r_timer <= r_timer - TMR_W'(1);
            end
        end
    end

    // Registered handshake and result outputs; counts include the closing edge's events
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_busy   <= 1'b0;
            r_valid  <= 1'b0;
            r_count0 <= '0;
            r_count1 <= '0;
        end else begin
            r_busy  <= w_busy_nxt;
            r_valid <= w_valid_nxt;
            if (w_capture) begin
                r_count0 <= w_c0_inc;
                r_count1 <= w_c1_inc;
            end
        end
    end

    assign bus.busy   = r_busy;
    assign bus.valid  = r_valid;
    assign bus.count0 = r_count0;
    assign bus.count1 = r_count1;
endmodule
